// File: rtl/dense_acc_pkg.sv
// rtl/dense_acc_pkg.sv - shared types, constants and helpers for the dense accumulate stage
package dense_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int N_IN_DEF   = 16;
  localparam int PROD_W_DEF = 19;
  localparam int BIAS_W_DEF = 12;
  localparam int ACC_W_DEF  = 24;
  localparam int SHIFT_DEF  = 6;
  localparam int OUT_W_DEF  = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic longint round_const(input int shift);
    return longint'(1) << (shift - 1);
  endfunction

  function automatic longint out_max(input int out_w);
    return (longint'(1) << (out_w - 1)) - 1;
  endfunction

  function automatic longint out_min(input int out_w);
    return -(longint'(1) << (out_w - 1));
  endfunction

  function automatic bit acc_w_ok(input int acc_w, input int prod_w, input int n_in);
    return acc_w >= prod_w + clog2(n_in) + 1;
  endfunction

  localparam longint ROUND_CONST = round_const(SHIFT_DEF);
  localparam longint OUT_MAX     = out_max(OUT_W_DEF);
  localparam longint OUT_MIN     = out_min(OUT_W_DEF);

endpackage

// File: rtl/dense_acc_stage_sat_round.sv
// rtl/dense_acc_stage_sat_round.sv - round-half-up shift and saturate of the accumulator
module sat_round
  import dense_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] data_o,
  output logic             ovf_o
);

  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(round_const(SHIFT));
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(out_max(OUT_W));
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(out_min(OUT_W));

  logic signed [ACC_W:0] sum_w;
  logic signed [ACC_W:0] shr_w;

  // One guard bit keeps the rounding add from wrapping near the top of the range.
  always_comb begin
    sum_w  = $signed({acc_i[ACC_W-1], acc_i}) + RND;
    shr_w  = sum_w >>> SHIFT;
    data_o = shr_w[OUT_W-1:0];
    ovf_o  = 1'b0;
    if (shr_w > MAXV) begin
      data_o = MAXV[OUT_W-1:0];
      ovf_o  = 1'b1;
    end else if (shr_w < MINV) begin
      data_o = MINV[OUT_W-1:0];
      ovf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/dense_acc_stage.sv
// rtl/dense_acc_stage.sv - accumulates one neuron's products onto a bias and emits a rounded result
module dense_acc_stage
  import dense_acc_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int PROD_W = PROD_W_DEF,
  parameter int BIAS_W = BIAS_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [BIAS_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              out_len_err
);

  localparam int CNT_W = clog2(N_IN + 1);

  if (!acc_w_ok(ACC_W, PROD_W, N_IN)) begin : g_bad_acc_w
    $error("ACC_W too narrow for PROD_W and N_IN");
  end

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_len_err_q, out_len_err_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   bias_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic [OUT_W-1:0]   sr_data;
  logic               sr_ovf;

  assign prod_ext = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
  assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);

  sat_round #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_sat_round (
    .acc_i (acc_q),
    .data_o(sr_data),
    .ovf_o (sr_ovf)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_ovf_d     = out_ovf_q;
    out_len_err_d = out_len_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d = bias_ext + prod_ext;
          cnt_d = CNT_W'(1);
          // A one-beat vector is always short because N_IN is at least 2.
          err_d = 1'b1;
          state_d = in_last ? ST_ROUND : ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_inc;
          if (in_last || (cnt_inc == CNT_W'(N_IN))) begin
            // Clean only when the last flag lands exactly on beat N_IN.
            err_d   = !(in_last && (cnt_inc == CNT_W'(N_IN)));
            state_d = ST_ROUND;
          end
        end
      end
      ST_ROUND: begin
        out_data_d    = sr_data;
        out_ovf_d     = sr_ovf;
        out_len_err_d = err_q;
        out_valid_d   = 1'b1;
        state_d       = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_ovf_q     <= 1'b0;
      out_len_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_ovf_q     <= out_ovf_d;
      out_len_err_q <= out_len_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ovf     = out_ovf_q;
  assign out_len_err = out_len_err_q;

endmodule

// File: tb/tb_dense_acc_stage.sv
// tb/tb_dense_acc_stage.sv - directed self-checking bench for dense_acc_stage
module tb_dense_acc_stage;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [18:0] in_data;
  logic               in_last;
  logic signed [11:0] bias;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_ovf;
  logic               out_len_err;

  int total = 0;
  int bad   = 0;

  dense_acc_stage dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .bias       (bias),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .out_len_err(out_len_err)
  );

  always #5 ap_clk = ~ap_clk;

  // Drives n back-to-back beats from one negedge to the next; returns on the negedge after the last accept.
  task automatic send_beats(input int n, input int val, input int b, input int last_pos);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 19'(val);
      bias     = 12'(b);
      in_last  = (i == last_pos);
      @(negedge ap_clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge ap_clk);
    end
  endtask

  task automatic test_reset;
    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    total++;
    if ({out_valid, out_data, out_ovf, out_len_err, in_ready} !== {1'b0, 16'sd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset: got valid=%b data=%0d ovf=%b len=%b rdy=%b want 0 0 0 0 1",
               out_valid, out_data, out_ovf, out_len_err, in_ready);
    end
  endtask

  task automatic test_basic;
    send_beats(16, 1024, 0, 15);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_round_cycle: got valid=%b rdy=%b want 0 0", out_valid, in_ready);
    end
    @(negedge ap_clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'sd256 || out_ovf !== 1'b0 || out_len_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got valid=%b data=%0d ovf=%b len=%b want 1 256 0 0",
               out_valid, out_data, out_ovf, out_len_err);
    end
    @(negedge ap_clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_consume: got valid=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_rounding;
    int b_tab[4]    = '{32, 31, -32, -33};
    int exp_tab[4]  = '{1, 0, 0, -1};
    bit ok;
    for (int k = 0; k < 4; k++) begin
      send_beats(16, 0, b_tab[k], 15);
      wait_valid(ok);
      total++;
      if (!ok || out_data !== 16'(exp_tab[k]) || out_ovf !== 1'b0) begin
        bad++;
        $display("FAIL round_bias_%0d: got valid=%b data=%0d ovf=%b want 1 %0d 0",
                 b_tab[k], out_valid, out_data, out_ovf, exp_tab[k]);
      end
      @(negedge ap_clk);
    end
  endtask

  task automatic test_saturate;
    bit ok;
    send_beats(16, 262143, 2047, 15);
    wait_valid(ok);
    total++;
    if (!ok || out_data !== 16'sd32767 || out_ovf !== 1'b1) begin
      bad++;
      $display("FAIL sat_pos: got valid=%b data=%0d ovf=%b want 1 32767 1", out_valid, out_data, out_ovf);
    end
    @(negedge ap_clk);
    send_beats(16, -262144, -2048, 15);
    wait_valid(ok);
    total++;
    if (!ok || out_data !== -16'sd32768 || out_ovf !== 1'b1) begin
      bad++;
      $display("FAIL sat_neg: got valid=%b data=%0d ovf=%b want 1 -32768 1", out_valid, out_data, out_ovf);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_backpressure;
    bit ok;
    int bad_hold;
    out_ready = 1'b0;
    send_beats(16, 64, 0, 15);
    wait_valid(ok);
    bad_hold = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 19'sd5;
      in_last  = 1'b1;
      @(negedge ap_clk);
      if (out_valid !== 1'b1 || out_data !== 16'sd16 || in_ready !== 1'b0) bad_hold++;
    end
    total++;
    if (!ok || bad_hold != 0) begin
      bad++;
      $display("FAIL hold: got found=%b bad_cycles=%0d data=%0d want 1 0 16", ok, bad_hold, out_data);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge ap_clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release: got valid=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    send_beats(16, 128, 0, 15);
    wait_valid(ok);
    total++;
    if (!ok || out_data !== 16'sd32 || out_len_err !== 1'b0) begin
      bad++;
      $display("FAIL after_release: got valid=%b data=%0d len=%b want 1 32 0", out_valid, out_data, out_len_err);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_length;
    bit ok;
    send_beats(10, 640, 0, 9);
    wait_valid(ok);
    total++;
    if (!ok || out_data !== 16'sd100 || out_len_err !== 1'b1) begin
      bad++;
      $display("FAIL len_short: got valid=%b data=%0d len=%b want 1 100 1", out_valid, out_data, out_len_err);
    end
    @(negedge ap_clk);
    send_beats(16, 320, 0, -1);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL len_force_term: got rdy=%b want 0", in_ready);
    end
    wait_valid(ok);
    total++;
    if (!ok || out_data !== 16'sd80 || out_len_err !== 1'b1) begin
      bad++;
      $display("FAIL len_no_last: got valid=%b data=%0d len=%b want 1 80 1", out_valid, out_data, out_len_err);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_gaps;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b0;
      in_data  = 19'sd77;
      repeat ($urandom_range(0, 3)) @(negedge ap_clk);
      in_valid = 1'b1;
      in_data  = 19'(i * 100 - 500);
      bias     = 12'sd100;
      in_last  = (i == 15);
      @(negedge ap_clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_valid(ok);
    total++;
    if (!ok || out_data !== 16'sd64 || out_len_err !== 1'b0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL gaps: got valid=%b data=%0d len=%b ovf=%b want 1 64 0 0",
               out_valid, out_data, out_len_err, out_ovf);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_mid_reset;
    bit ok;
    int spurious;
    send_beats(7, 1000, 0, -1);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    total++;
    if ({out_valid, out_data, out_ovf, out_len_err, in_ready} !== {1'b0, 16'sd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset: got valid=%b data=%0d ovf=%b len=%b rdy=%b want 0 0 0 0 1",
               out_valid, out_data, out_ovf, out_len_err, in_ready);
    end
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ap_clk);
      if (out_valid !== 1'b0) spurious++;
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL mid_reset_no_output: got %0d valid cycles want 0", spurious);
    end
    send_beats(16, 64, 0, 15);
    wait_valid(ok);
    total++;
    if (!ok || out_data !== 16'sd16 || out_len_err !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_vec: got valid=%b data=%0d len=%b want 1 16 0", out_valid, out_data, out_len_err);
    end
    @(negedge ap_clk);
  endtask

  initial begin
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b1;
    @(negedge ap_clk);
    test_reset;
    test_basic;
    test_rounding;
    test_saturate;
    test_backpressure;
    test_length;
    test_gaps;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
